sram_wb_arbiter: RTL and testbench
==================================

// Module: sram_wb_arbiter
// PURPOSE
//  Shares the single Wishbone slave port of the 2KB secure-memory SRAM wrapper
//  between two Wishbone masters: m0 (Caravel management bus) and m1 (internal engine).
//  Also owns a zeroize sequencer that overwrites every SRAM word with 0 on request.
//  Sits between the user-project bus fabric and the SRAM wrapper.
//  The SRAM wrapper acks one cycle after stb and never acks two cycles in a row.
// PARAMETERS
//  AW     9     SRAM word-address width; zeroize walks 0 .. 2**AW-1
//  DW     32    data width; byte-select width is DW/8
// PORTS
//  wb_clk_i      in   1      system clock; all logic on posedge
//  rst_n         in   1      reset, synchronous, active-low
//  m0_cyc_i      in   1      master 0 cycle
//  m0_stb_i      in   1      master 0 strobe
//  m0_we_i       in   1      master 0 write enable
//  m0_adr_i      in   AW     master 0 word address
//  m0_dat_i      in   DW     master 0 write data
//  m0_sel_i      in   DW/8   master 0 byte selects
//  m0_dat_o      out  DW     read data (= s_dat_i)
//  m0_ack_o      out  1      master 0 acknowledge
//  m1_*          same set as m0_*, for master 1
//  s_cyc_o       out  1      to SRAM wrapper: cycle
//  s_stb_o       out  1      to SRAM wrapper: strobe
//  s_we_o        out  1      to SRAM wrapper: write enable
//  s_adr_o       out  AW     to SRAM wrapper: word address
//  s_dat_o       out  DW     to SRAM wrapper: write data
//  s_sel_o       out  DW/8   to SRAM wrapper: byte selects
//  s_dat_i       in   DW     from SRAM wrapper: read data
//  s_ack_i       in   1      from SRAM wrapper: acknowledge
//  zeroize_req_i in   1      1-cycle pulse; requests a full memory clear
//  zeroize_busy_o out 1      high while the clear is in progress
//  zeroize_done_o out 1      1-cycle pulse after the last word is written
// BEHAVIOUR
//  - Reset: state=IDLE, last_owner=M1, zero_pend=0, zaddr=0.
//  - Reset: all outputs are 0; reset mid-operation aborts any transfer or clear, with no done pulse.
//  - Request: mN_req = mN_cyc_i & mN_stb_i.
//  - zero_pend is set by zeroize_req_i in any state except ZERO; a pulse during ZERO is ignored.
//  - FSM states: IDLE, M0, M1, ZERO.
//  - IDLE priority: zero_pend > round-robin between masters.
//  - Round-robin: if both masters request, grant the one != last_owner; the first grant after reset goes to m0.
//  - IDLE outputs: s_cyc/s_stb/s_we/s_adr/s_dat/s_sel all 0.
//  - IDLE -> MN: s_* is a combinational copy of mN_*, with s_cyc=s_stb=1.
//  - MN: mN_ack_o = s_ack_i; the other master's ack is 0.
//  - MN exit: on s_ack_i go to IDLE, set last_owner=N. The mandatory IDLE cycle gives s_stb=0 between grants.
//  - MN abort: if mN_req drops before ack, go to IDLE with no ack and no last_owner update.
//  - Master latency: req seen in IDLE at edge k -> s_stb high in cycle k+1 -> mN_ack_o in cycle k+2.
//  - Read data: m0_dat_o and m1_dat_o both equal s_dat_i; only the acked master may sample it.
//  - Stall: requests that arrive during another grant or during ZERO are held off (ack=0), never dropped.
//  - ZERO entry: IDLE -> ZERO clears zero_pend; zeroize_busy_o=1 while in ZERO.
//  - ZERO outputs: s_cyc=s_stb=1, s_we=1, s_sel=all 1s, s_dat=0, s_adr=zaddr.
//  - ZERO step: on s_ack_i, zaddr += 1 and s_stb stays high. The ack cycle re-writes the same word, which is harmless.
//  - ZERO rate: 2 cycles per word, 2*2**AW cycles total.
//  - ZERO exit: on the ack for zaddr = 2**AW-1, zaddr wraps to 0, go to IDLE, and pulse zeroize_done_o the next cycle.
//  - Mutual exclusion: at most one of m0_ack_o and m1_ack_o is high in any cycle; neither is high in ZERO.
// TESTING
//  - m0 write 0xDEADBEEF @0x010 sel=0xF, then m0 read @0x010 -> ack 2 cycles after req; dat=0xDEADBEEF.
//  - m0 and m1 request reads in the same cycle, both held -> grant order m0,m1,m0,m1; never two acks in one cycle.
//  - m1 writes sel=0x3 data 0xAAAA5555 over 0x12345678 @0x1F0 -> read back 0x12345678 & 0xFFFF0000 | 0x00005555 = 0x12345555.
//  - Fill 0x1FF with 0xFFFFFFFF, pulse zeroize -> busy for 1024 cycles, one done pulse; reads @0x000/0x1FF return 0.
//  - m0 read held during zeroize -> no ack until done, then acked with 0; a second zeroize_req during ZERO is ignored.
//  - rst_n low mid-zeroize @zaddr=0x080 -> all outputs 0 and no done pulse; next grant after reset goes to m0.

Source files
------------

// File: rtl/sram_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the secure-memory SRAM wrapper,
// with a zeroize sequencer that clears every word on request.
module sram_wb_arbiter #(
   parameter int unsigned AW = 9,
   parameter int unsigned DW = 32
) (
   input  logic              wb_clk_i,
   input  logic              rst_n,
   input  logic              m0_cyc_i,
   input  logic              m0_stb_i,
   input  logic              m0_we_i,
   input  logic [AW-1:0]     m0_adr_i,
   input  logic [DW-1:0]     m0_dat_i,
   input  logic [DW/8-1:0]   m0_sel_i,
   output logic [DW-1:0]     m0_dat_o,
   output logic              m0_ack_o,
   input  logic              m1_cyc_i,
   input  logic              m1_stb_i,
   input  logic              m1_we_i,
   input  logic [AW-1:0]     m1_adr_i,
   input  logic [DW-1:0]     m1_dat_i,
   input  logic [DW/8-1:0]   m1_sel_i,
   output logic [DW-1:0]     m1_dat_o,
   output logic              m1_ack_o,
   output logic              s_cyc_o,
   output logic              s_stb_o,
   output logic              s_we_o,
   output logic [AW-1:0]     s_adr_o,
   output logic [DW-1:0]     s_dat_o,
   output logic [DW/8-1:0]   s_sel_o,
   input  logic [DW-1:0]     s_dat_i,
   input  logic              s_ack_i,
   input  logic              zeroize_req_i,
   output logic              zeroize_busy_o,
   output logic              zeroize_done_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_M0, ST_M1, ST_ZERO} state_t;

   localparam logic OWN_M0 = 1'b0;
   localparam logic OWN_M1 = 1'b1;

   state_t        state_q, state_d;
   logic          owner_q, owner_d;
   logic          zero_pend_q, zero_pend_d;
   logic [AW-1:0] zaddr_q, zaddr_d;
   logic          done_q, done_d;
   logic          m0_req, m1_req;

   assign m0_req = m0_cyc_i & m0_stb_i;
   assign m1_req = m1_cyc_i & m1_stb_i;

   // Next-state: grant selection, transfer completion/abort, clear walk
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      zaddr_d     = zaddr_q;
      done_d      = 1'b0;
      zero_pend_d = zero_pend_q | (zeroize_req_i & (state_q != ST_ZERO));
      case (state_q)
         ST_IDLE: begin
            if (zero_pend_q) begin
               state_d     = ST_ZERO;
               zero_pend_d = zeroize_req_i;
            end else if (m0_req && m1_req) begin
               state_d = (owner_q == OWN_M1) ? ST_M0 : ST_M1;
            end else if (m0_req) begin
               state_d = ST_M0;
            end else if (m1_req) begin
               state_d = ST_M1;
            end
         end
         ST_M0: begin
            if (s_ack_i) begin
               state_d = ST_IDLE;
               owner_d = OWN_M0;
            end else if (!m0_req) begin
               state_d = ST_IDLE;
            end
         end
         ST_M1: begin
            if (s_ack_i) begin
               state_d = ST_IDLE;
               owner_d = OWN_M1;
            end else if (!m1_req) begin
               state_d = ST_IDLE;
            end
         end
         ST_ZERO: begin
            if (s_ack_i) begin
               zaddr_d = zaddr_q + AW'(1);
               if (zaddr_q == '1) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_M1;
         zero_pend_q <= 1'b0;
         zaddr_q     <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         zero_pend_q <= zero_pend_d;
         zaddr_q     <= zaddr_d;
         done_q      <= done_d;
      end
   end

   // Slave-side mux and ack steering; held at zero while reset is asserted
   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
      if (rst_n) begin
         case (state_q)
            ST_M0: begin
               s_cyc_o  = 1'b1;
               s_stb_o  = 1'b1;
               s_we_o   = m0_we_i;
               s_adr_o  = m0_adr_i;
               s_dat_o  = m0_dat_i;
               s_sel_o  = m0_sel_i;
               m0_ack_o = s_ack_i;
            end
            ST_M1: begin
               s_cyc_o  = 1'b1;
               s_stb_o  = 1'b1;
               s_we_o   = m1_we_i;
               s_adr_o  = m1_adr_i;
               s_dat_o  = m1_dat_i;
               s_sel_o  = m1_sel_i;
               m1_ack_o = s_ack_i;
            end
            ST_ZERO: begin
               s_cyc_o = 1'b1;
               s_stb_o = 1'b1;
               s_we_o  = 1'b1;
               s_adr_o = zaddr_q;
               s_sel_o = '1;
            end
            default: ;
         endcase
      end
   end

   assign m0_dat_o       = rst_n ? s_dat_i : '0;
   assign m1_dat_o       = rst_n ? s_dat_i : '0;
   assign zeroize_busy_o = rst_n & (state_q == ST_ZERO);
   assign zeroize_done_o = rst_n & done_q;

endmodule

// File: tb/tb_sram_wb_arbiter.sv
// Bench for sram_wb_arbiter: SRAM wrapper model, memory-level reference model,
// per-cycle monitor, directed scenarios and randomized two-master traffic.
module tb_sram_wb_arbiter;
   localparam int unsigned AW = 9;
   localparam int unsigned DW = 32;
   localparam int unsigned NW = 512;

   logic          wb_clk_i = 1'b0;
   logic          rst_n = 1'b0;
   logic          m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
   logic [AW-1:0] m0_adr_i = '0;
   logic [DW-1:0] m0_dat_i = '0;
   logic [3:0]    m0_sel_i = '0;
   logic [DW-1:0] m0_dat_o;
   logic          m0_ack_o;
   logic          m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
   logic [AW-1:0] m1_adr_i = '0;
   logic [DW-1:0] m1_dat_i = '0;
   logic [3:0]    m1_sel_i = '0;
   logic [DW-1:0] m1_dat_o;
   logic          m1_ack_o;
   logic          s_cyc_o, s_stb_o, s_we_o;
   logic [AW-1:0] s_adr_o;
   logic [DW-1:0] s_dat_o;
   logic [3:0]    s_sel_o;
   logic [DW-1:0] s_dat_i;
   logic          s_ack_i;
   logic          zeroize_req_i = 1'b0;
   logic          zeroize_busy_o, zeroize_done_o;

   int n_chk = 0;
   int n_err = 0;
   int zdone_cnt = 0;
   int ack_log[$];

   logic [DW-1:0] sram [NW] = '{default: '0};
   logic [DW-1:0] model_mem [NW] = '{default: '0};
   logic          sram_ack = 1'b0;
   logic [DW-1:0] sram_dat = '0;

   always #5 wb_clk_i = ~wb_clk_i;

   sram_wb_arbiter #(.AW(AW), .DW(DW)) dut (
      .wb_clk_i(wb_clk_i), .rst_n(rst_n),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
      .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
      .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
      .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .zeroize_req_i(zeroize_req_i), .zeroize_busy_o(zeroize_busy_o),
      .zeroize_done_o(zeroize_done_o)
   );

   // SRAM wrapper: acks one cycle after stb, never two acks in a row
   always @(posedge wb_clk_i) begin
      if (!rst_n) begin
         sram_ack <= 1'b0;
      end else begin
         sram_ack <= s_stb_o & ~sram_ack;
         if (s_stb_o && !sram_ack) begin
            if (s_we_o) begin
               for (int b = 0; b < 4; b++)
                  if (s_sel_o[b]) sram[s_adr_o][8*b +: 8] <= s_dat_o[8*b +: 8];
            end else begin
               sram_dat <= sram[s_adr_o];
            end
         end
      end
   end
   assign s_ack_i = sram_ack;
   assign s_dat_i = sram_dat;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Per-cycle monitor: protocol rules plus read data against the memory model
   initial begin : monitor
      int run;
      bit prev_busy;
      run = 0;
      prev_busy = 0;
      forever begin
         @(negedge wb_clk_i);
         if (!rst_n) begin
            run = 0;
            prev_busy = 0;
         end else begin
            chk("ack_excl", 64'(m0_ack_o & m1_ack_o), 64'(0));
            chk("ack0_noreq", 64'(m0_ack_o & ~(m0_cyc_i & m0_stb_i)), 64'(0));
            chk("ack1_noreq", 64'(m1_ack_o & ~(m1_cyc_i & m1_stb_i)), 64'(0));
            if (zeroize_busy_o) begin
               chk("ack_in_zero", 64'({m0_ack_o, m1_ack_o}), 64'(0));
               chk("zero_bus", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_dat_o}),
                   64'({3'b111, 4'hF, 32'h0}));
            end
            if (zeroize_done_o) begin
               zdone_cnt++;
               chk("zero_len", 64'(prev_busy ? run : 0), 64'(1024));
               for (int i = 0; i < int'(NW); i++) model_mem[i] = '0;
            end
            run = zeroize_busy_o ? (prev_busy ? run + 1 : 1) : run;
            prev_busy = zeroize_busy_o;
            if (m0_ack_o) begin
               ack_log.push_back(0);
               if (m0_we_i) begin
                  for (int b = 0; b < 4; b++)
                     if (m0_sel_i[b]) model_mem[m0_adr_i][8*b +: 8] = m0_dat_i[8*b +: 8];
               end else chk("rd_m0", 64'(m0_dat_o), 64'(model_mem[m0_adr_i]));
            end
            if (m1_ack_o) begin
               ack_log.push_back(1);
               if (m1_we_i) begin
                  for (int b = 0; b < 4; b++)
                     if (m1_sel_i[b]) model_mem[m1_adr_i][8*b +: 8] = m1_dat_i[8*b +: 8];
               end else chk("rd_m1", 64'(m1_dat_o), 64'(model_mem[m1_adr_i]));
            end
         end
      end
   end

   // One Wishbone transfer on master m; lat = cycles from request to ack
   task automatic xfer(input int m, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [3:0] s,
                       output logic [DW-1:0] rd, output int lat);
      bit got;
      got = 0;
      lat = 0;
      rd = '0;
      if (m == 0) begin
         m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = we; m0_adr_i = a; m0_dat_i = d; m0_sel_i = s;
      end else begin
         m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = we; m1_adr_i = a; m1_dat_i = d; m1_sel_i = s;
      end
      for (int i = 0; i < 1500 && !got; i++) begin
         @(negedge wb_clk_i);
         if ((m == 0) ? m0_ack_o : m1_ack_o) begin
            got = 1;
            rd = (m == 0) ? m0_dat_o : m1_dat_o;
         end else lat++;
      end
      #1;
      if (m == 0) begin
         m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
      end else begin
         m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
      end
      if (!got) begin
         n_chk++;
         n_err++;
         $display("FAIL xfer_timeout: master=%0d no ack within 1500 cycles", m);
      end
   endtask

   task automatic pulse_zero();
      @(posedge wb_clk_i); #1 zeroize_req_i = 1'b1;
      @(posedge wb_clk_i); #1 zeroize_req_i = 1'b0;
   endtask

   task automatic wait_done(output int busy_cycles);
      bit got;
      got = 0;
      busy_cycles = 0;
      for (int i = 0; i < 1300 && !got; i++) begin
         @(negedge wb_clk_i);
         if (zeroize_busy_o) busy_cycles++;
         if (zeroize_done_o) got = 1;
      end
      #1;
      if (!got) begin
         n_chk++;
         n_err++;
         $display("FAIL zero_timeout: no done pulse within 1300 cycles");
      end
   endtask

   task automatic rand_master(input int m, input int n);
      logic [DW-1:0] rd;
      int lat;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge wb_clk_i);
         #1;
         xfer(m, 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, 15) + ($urandom_range(0, 1) ? 32'h1F0 : 32'h0)),
              $urandom, 4'($urandom_range(0, 15)), rd, lat);
      end
   endtask

   task automatic chk_outputs_zero(input string nm);
      chk(nm, 64'({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, m0_ack_o, m1_ack_o,
                  zeroize_busy_o, zeroize_done_o}), 64'(0));
      chk({nm, "_dat"}, {s_dat_o, m0_dat_o | m1_dat_o}, 64'(0));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [DW-1:0] rd;
      int lat, bc, base;
      repeat (3) @(posedge wb_clk_i);
      #1 chk_outputs_zero("reset_out");
      rst_n = 1'b1;

      // Bring memory to a known all-zero state
      pulse_zero();
      wait_done(bc);
      chk("zero_busy_cycles", 64'(bc), 64'(1024));

      // m0 write then read, latency from an idle bus
      xfer(0, 1, 9'h010, 32'hDEADBEEF, 4'hF, rd, lat);
      @(posedge wb_clk_i); #1;
      xfer(0, 0, 9'h010, 32'h0, 4'hF, rd, lat);
      chk("m0_rd_latency", 64'(lat), 64'(2));
      chk("m0_rd_data", 64'(rd), 64'(32'hDEADBEEF));

      // Round-robin with both masters held; last owner set to m1 first
      xfer(1, 0, 9'h011, 32'h0, 4'hF, rd, lat);
      @(posedge wb_clk_i); #1;
      ack_log.delete();
      fork
         begin
            xfer(0, 0, 9'h020, 0, 4'hF, rd, lat);
            xfer(0, 0, 9'h021, 0, 4'hF, rd, lat);
         end
         begin : m1_rr
            logic [DW-1:0] rd1;
            int lat1;
            xfer(1, 0, 9'h022, 0, 4'hF, rd1, lat1);
            xfer(1, 0, 9'h023, 0, 4'hF, rd1, lat1);
         end
      join
      chk("rr_count", 64'(ack_log.size()), 64'(4));
      if (ack_log.size() == 4)
         chk("rr_order", 64'({ack_log[0][3:0], ack_log[1][3:0], ack_log[2][3:0], ack_log[3][3:0]}),
             64'(16'h0101));

      // Partial byte-select write by m1
      xfer(1, 1, 9'h1F0, 32'h12345678, 4'hF, rd, lat);
      xfer(1, 1, 9'h1F0, 32'hAAAA5555, 4'h3, rd, lat);
      xfer(1, 0, 9'h1F0, 32'h0, 4'hF, rd, lat);
      chk("m1_sel_merge", 64'(rd), 64'(32'h12345555));

      // Zeroize with m0 read held off and a second ignored request
      xfer(0, 1, 9'h1FF, 32'hFFFFFFFF, 4'hF, rd, lat);
      base = zdone_cnt;
      pulse_zero();
      fork
         begin : held_rd
            logic [DW-1:0] rdh;
            int lath;
            xfer(0, 0, 9'h1FF, 32'h0, 4'hF, rdh, lath);
            chk("held_rd_data", 64'(rdh), 64'(0));
            chk("held_rd_after_done", 64'(zdone_cnt), 64'(base + 1));
         end
         begin
            repeat (20) @(posedge wb_clk_i);
            pulse_zero();
         end
         begin : zwait
            int bcz;
            wait_done(bcz);
            chk("zero2_busy_cycles", 64'(bcz), 64'(1024));
         end
      join
      repeat (30) @(posedge wb_clk_i);
      #1 chk("zero_second_ignored", 64'({zeroize_busy_o, 8'(zdone_cnt - base)}), 64'(1));
      xfer(1, 0, 9'h000, 32'h0, 4'hF, rd, lat);
      chk("zero_rd_000", 64'(rd), 64'(0));

      // Randomized concurrent traffic with occasional clears
      fork
         rand_master(0, 60);
         rand_master(1, 60);
         repeat (2) begin
            repeat ($urandom_range(50, 150)) @(posedge wb_clk_i);
            pulse_zero();
         end
      join
      repeat (1100) begin
         @(negedge wb_clk_i);
         if (!zeroize_busy_o) break;
      end
      repeat (3) @(posedge wb_clk_i);

      // Reset in the middle of a clear
      base = zdone_cnt;
      pulse_zero();
      lat = 0;
      for (int i = 0; i < 600 && lat == 0; i++) begin
         @(negedge wb_clk_i);
         if (zeroize_busy_o && s_adr_o == 9'h080) lat = 1;
      end
      chk("reach_zaddr_080", 64'(lat), 64'(1));
      #1 rst_n = 1'b0;
      #1 chk_outputs_zero("midrst_out");
      repeat (3) @(posedge wb_clk_i);
      #1 chk_outputs_zero("midrst_hold");
      rst_n = 1'b1;
      repeat (10) @(posedge wb_clk_i);
      #1 chk("post_rst_idle", 64'({zeroize_busy_o, 8'(zdone_cnt - base)}), 64'(0));
      ack_log.delete();
      fork
         xfer(0, 0, 9'h100, 0, 4'hF, rd, lat);
         begin : m1_after_rst
            logic [DW-1:0] rd2;
            int lat2;
            xfer(1, 0, 9'h101, 0, 4'hF, rd2, lat2);
         end
      join
      chk("post_rst_first_grant", 64'(ack_log.size() > 0 ? ack_log[0] : 9), 64'(0));

      // Full clear to resynchronise, then final readbacks
      pulse_zero();
      wait_done(bc);
      xfer(0, 0, 9'h1FF, 32'h0, 4'hF, rd, lat);
      chk("final_rd_1ff", 64'(rd), 64'(0));
      xfer(1, 0, 9'h080, 32'h0, 4'hF, rd, lat);
      chk("final_rd_080", 64'(rd), 64'(0));
      repeat (3) @(posedge wb_clk_i);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
